// File: rtl/sbox_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sbox_pipe (with helper sbox_gf4_mul)
// Brief    : 3-stage AES forward/inverse S-box using composite-field inversion.
// Revision : 1.0
// ============================================================================

module sbox_gf4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);
    // GF(2^4) modulo x^4 + x + 1
    logic [3:0] w_x1;
    logic [3:0] w_x2;
    logic [3:0] w_x3;

    assign w_x1 = {a[2:0],    1'b0} ^ {2'b00, a[3],    a[3]};
    assign w_x2 = {w_x1[2:0], 1'b0} ^ {2'b00, w_x1[3], w_x1[3]};
    assign w_x3 = {w_x2[2:0], 1'b0} ^ {2'b00, w_x2[3], w_x2[3]};

    assign p = (a    & {4{b[0]}}) ^ (w_x1 & {4{b[1]}}) ^
               (w_x2 & {4{b[2]}}) ^ (w_x3 & {4{b[3]}});
endmodule

module sbox_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_dec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_dec,
    output logic [1:0] occupancy
);
    localparam logic [8:0] C_AES_POLY = 9'h11B;

    function automatic logic [3:0] f_gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
        end
        return acc;
    endfunction

    // Smallest lambda making y^2 + y + lambda irreducible over GF(2^4)
    function automatic logic [3:0] f_find_lambda();
        logic [3:0] lam;
        logic       found;
        logic       has_root;
        lam   = 4'h0;
        found = 1'b0;
        for (int l = 1; l < 16; l++) begin
            has_root = 1'b0;
            for (int y = 0; y < 16; y++) begin
                if ((f_gf4_mul(4'(y), 4'(y)) ^ 4'(y) ^ 4'(l)) == 4'h0) has_root = 1'b1;
            end
            if (!has_root && !found) begin
                lam   = 4'(l);
                found = 1'b1;
            end
        end
        return lam;
    endfunction

    function automatic logic [7:0] f_gf8_mul(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] lam);
        logic [3:0] hh;
        hh = f_gf4_mul(a[7:4], b[7:4]);
        return {hh ^ f_gf4_mul(a[7:4], b[3:0]) ^ f_gf4_mul(a[3:0], b[7:4]),
                f_gf4_mul(hh, lam) ^ f_gf4_mul(a[3:0], b[3:0])};
    endfunction

    // Tower-field root of the AES polynomial; its powers form the basis change
    function automatic logic [7:0] f_find_beta(input logic [3:0] lam);
        logic [7:0] beta;
        logic [7:0] pw;
        logic [7:0] acc;
        logic       found;
        beta  = 8'h00;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            pw  = 8'h01;
            acc = 8'h00;
            for (int i = 0; i < 9; i++) begin
                if (C_AES_POLY[i]) acc = acc ^ pw;
                pw = f_gf8_mul(pw, 8'(c), lam);
            end
            if (acc == 8'h00 && !found) begin
                beta  = 8'(c);
                found = 1'b1;
            end
        end
        return beta;
    endfunction

    function automatic logic [63:0] f_tower_cols(input logic [7:0] beta, input logic [3:0] lam);
        logic [63:0] cols;
        logic [7:0]  pw;
        cols = 64'h0;
        pw   = 8'h01;
        for (int i = 0; i < 8; i++) begin
            cols[8*i +: 8] = pw;
            pw = f_gf8_mul(pw, beta, lam);
        end
        return cols;
    endfunction

    function automatic logic [7:0] f_apply(input logic [63:0] cols, input logic [7:0] x);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) acc = acc ^ cols[8*i +: 8];
        end
        return acc;
    endfunction

    function automatic logic [63:0] f_inv_cols(input logic [63:0] fwd);
        logic [63:0] cols;
        cols = 64'h0;
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 256; b++) begin
                if (f_apply(fwd, 8'(b)) == (8'h01 << j)) cols[8*j +: 8] = 8'(b);
            end
        end
        return cols;
    endfunction

    function automatic logic [7:0] f_rotl(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    localparam logic [3:0]  C_LAMBDA     = f_find_lambda();
    localparam logic [7:0]  C_BETA       = f_find_beta(C_LAMBDA);
    localparam logic [63:0] C_TO_TOWER   = f_tower_cols(C_BETA, C_LAMBDA);
    localparam logic [63:0] C_FROM_TOWER = f_inv_cols(C_TO_TOWER);

    logic       w_en;
    logic       r_s1_valid;
    logic       r_s2_valid;
    logic [3:0] r_s1_ah;
    logic [3:0] r_s1_sum;
    logic [3:0] r_s1_d;
    logic       r_s1_dec;
    logic [3:0] r_s2_ah;
    logic [3:0] r_s2_sum;
    logic [3:0] r_s2_dinv;
    logic       r_s2_dec;

    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    assign occupancy = {1'b0, r_s1_valid} + {1'b0, r_s2_valid} + {1'b0, out_valid};

    // Stage 1: optional inverse affine, basis change, norm d = lambda*ah^2 + al*(ah^al)
    logic [7:0] w_s1_invaff;
    logic [7:0] w_s1_pre;
    logic [7:0] w_s1_tw;
    logic [3:0] w_s1_sum;
    logic [3:0] w_s1_ahsq;
    logic [3:0] w_s1_lsq;
    logic [3:0] w_s1_cross;

    assign w_s1_invaff = f_rotl(in_data, 1) ^ f_rotl(in_data, 3) ^ f_rotl(in_data, 6) ^ 8'h05;
    assign w_s1_pre    = in_dec ? w_s1_invaff : in_data;
    assign w_s1_tw     = f_apply(C_TO_TOWER, w_s1_pre);
    assign w_s1_sum    = w_s1_tw[7:4] ^ w_s1_tw[3:0];

    sbox_gf4_mul u_s1_sq    (.a(w_s1_tw[7:4]), .b(w_s1_tw[7:4]), .p(w_s1_ahsq));
    sbox_gf4_mul u_s1_lsq   (.a(w_s1_ahsq),    .b(C_LAMBDA),     .p(w_s1_lsq));
    sbox_gf4_mul u_s1_cross (.a(w_s1_tw[3:0]), .b(w_s1_sum),     .p(w_s1_cross));

    // Stage 2: d^-1 = d^14 = d^2 * d^4 * d^8, which also maps 0 to 0
    logic [3:0] w_s2_x2;
    logic [3:0] w_s2_x4;
    logic [3:0] w_s2_x8;
    logic [3:0] w_s2_x6;
    logic [3:0] w_s2_x14;

    sbox_gf4_mul u_s2_sq2 (.a(r_s1_d),  .b(r_s1_d),  .p(w_s2_x2));
    sbox_gf4_mul u_s2_sq4 (.a(w_s2_x2), .b(w_s2_x2), .p(w_s2_x4));
    sbox_gf4_mul u_s2_sq8 (.a(w_s2_x4), .b(w_s2_x4), .p(w_s2_x8));
    sbox_gf4_mul u_s2_m6  (.a(w_s2_x2), .b(w_s2_x4), .p(w_s2_x6));
    sbox_gf4_mul u_s2_m14 (.a(w_s2_x6), .b(w_s2_x8), .p(w_s2_x14));

    // Stage 3: inverse = ah*d^-1 : (ah^al)*d^-1, back to polynomial basis
    logic [3:0] w_s3_hi;
    logic [3:0] w_s3_lo;
    logic [7:0] w_s3_poly;
    logic [7:0] w_s3_fwd;
    logic [7:0] w_s3_result;

    sbox_gf4_mul u_s3_hi (.a(r_s2_ah),  .b(r_s2_dinv), .p(w_s3_hi));
    sbox_gf4_mul u_s3_lo (.a(r_s2_sum), .b(r_s2_dinv), .p(w_s3_lo));

    assign w_s3_poly   = f_apply(C_FROM_TOWER, {w_s3_hi, w_s3_lo});
    assign w_s3_fwd    = w_s3_poly ^ f_rotl(w_s3_poly, 1) ^ f_rotl(w_s3_poly, 2) ^
                         f_rotl(w_s3_poly, 3) ^ f_rotl(w_s3_poly, 4) ^ 8'h63;
    assign w_s3_result = r_s2_dec ? w_s3_poly : w_s3_fwd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_dec    <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            out_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                out_data <= w_s3_result;
                out_dec  <= r_s2_dec;
            end
        end
    end

    // Datapath registers carry no reset; the valid bits gate everything
    always_ff @(posedge clk) begin
        if (w_en && in_valid) begin
            r_s1_ah  <= w_s1_tw[7:4];
            r_s1_sum <= w_s1_sum;
            r_s1_d   <= w_s1_lsq ^ w_s1_cross;
            r_s1_dec <= in_dec;
        end
        if (w_en && r_s1_valid) begin
            r_s2_ah   <= r_s1_ah;
            r_s2_sum  <= r_s1_sum;
            r_s2_dinv <= w_s2_x14;
            r_s2_dec  <= r_s1_dec;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sbox_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_pipe
// Brief    : Scoreboard bench for sbox_pipe against a FIPS-197 table model.
// Revision : 1.0
// ============================================================================
module tb_sbox_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_dec = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_dec;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    always #5 clk = ~clk;

    sbox_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dec   (out_dec),
        .occupancy (occupancy)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         bp_mode = 0;
    logic       started = 1'b0;
    logic [8:0] q[$];
    logic [7:0] s_tab[256];
    logic [7:0] is_tab[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] aes_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (aes_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
                       inv[(i + 7) % 8] ^ c[i];
            s_tab[x]  = s;
            is_tab[s] = 8'(x);
        end
    endtask

    task automatic set_ready();
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_dec   = 1'($urandom);
        set_ready();
    endtask

    task automatic send(input logic [7:0] d, input logic dec, input logic [7:0] exp);
        int   w;
        logic done;
        w    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_dec   = dec;
            set_ready();
            #1;
            if (in_ready) begin
                q.push_back({dec, exp});
                done = 1'b1;
            end else if (++w > 200) begin
                check("accept_timeout", {31'b0, in_ready}, 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        bp_mode = 0;
        while (q.size() != 0 && w < 100) begin
            idle();
            w++;
        end
        idle();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_dec   = 1'($urandom);
        set_ready();
        #1;
        q.delete();
        repeat (cycles - 1) begin
            @(negedge clk);
            in_data = 8'($urandom);
            set_ready();
        end
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_occupancy", {30'b0, occupancy}, 0);
        check("rst_out_data", {24'b0, out_data}, 0);
        check("rst_out_dec", {31'b0, out_dec}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        set_ready();
    endtask

    // Monitor: occupancy vs outstanding count, hold stability, in-order results
    initial begin
        logic       hold;
        logic [8:0] held;
        logic [8:0] exp9;
        hold = 1'b0;
        held = 9'h0;
        wait (started);
        forever begin
            @(negedge clk);
            check("occupancy", {30'b0, occupancy}, q.size());
            #2;
            if (hold) begin
                check("hold_valid", {31'b0, out_valid}, 1);
                check("hold_data", {23'b0, out_dec, out_data}, {23'b0, held});
            end
            hold = rst_n && out_valid && !out_ready;
            held = {out_dec, out_data};
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {31'b0, out_valid}, 0);
                end else begin
                    exp9 = q.pop_front();
                    check("result", {23'b0, out_dec, out_data}, {23'b0, exp9});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pairs[512];
        int         j;
        int         tmp;
        logic [7:0] bts[4];
        logic [7:0] exps[4];

        build_tables();
        bp_mode = 0;
        do_reset(3);
        started = 1'b1;

        // Single byte latency: out_valid on the third edge counting acceptance
        send(8'h00, 1'b0, 8'h63);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            set_ready();
            #1;
            check("latency_valid", {31'b0, out_valid}, (k == 3) ? 1 : 0);
        end
        drain();

        // Forward stream
        send(8'h00, 1'b0, 8'h63);
        send(8'h01, 1'b0, 8'h7C);
        send(8'h53, 1'b0, 8'hED);
        send(8'hFF, 1'b0, 8'h16);
        idle();
        check("fwd_occ_peak", {30'b0, occupancy}, 3);
        drain();

        // Inverse stream
        send(8'h63, 1'b1, 8'h00);
        send(8'hED, 1'b1, 8'h53);
        send(8'h16, 1'b1, 8'hFF);
        send(8'h00, 1'b1, 8'h52);
        drain();

        // Interleaved modes on the same byte
        for (int k = 0; k < 8; k++) send(8'h53, 1'(k), (k % 2 == 1) ? 8'h50 : 8'hED);
        drain();

        // Backpressure: three fill the pipe, the fourth must wait
        bts  = '{8'h10, 8'h20, 8'h30, 8'h40};
        exps = '{8'hCA, 8'hB7, 8'h04, 8'h09};
        bp_mode = 2;
        for (int k = 0; k < 3; k++) send(bts[k], 1'b0, exps[k]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = bts[3];
            in_dec   = 1'b0;
            set_ready();
            #1;
        end
        check("bp_in_ready", {31'b0, in_ready}, 0);
        check("bp_occupancy", {30'b0, occupancy}, 3);
        check("bp_out_valid", {31'b0, out_valid}, 1);
        bp_mode = 0;
        send(bts[3], 1'b0, exps[3]);
        drain();

        // Reset with two bytes in flight
        send(8'hAA, 1'b0, s_tab[8'hAA]);
        send(8'h55, 1'b1, is_tab[8'h55]);
        do_reset(1);
        idle();
        check("post_rst_valid", {31'b0, out_valid}, 0);
        send(8'hC3, 1'b0, s_tab[8'hC3]);
        send(8'h3C, 1'b1, is_tab[8'h3C]);
        drain();

        // All 512 (byte, mode) pairs, shuffled, with random gaps and backpressure
        for (int i = 0; i < 512; i++) pairs[i] = i;
        for (int i = 511; i > 0; i--) begin
            j        = int'($urandom_range(0, i));
            tmp      = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end
        bp_mode = 1;
        for (int i = 0; i < 512; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            if (pairs[i][8]) send(8'(pairs[i]), 1'b1, is_tab[pairs[i][7:0]]);
            else             send(8'(pairs[i]), 1'b0, s_tab[pairs[i][7:0]]);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
